gelato_fetch_scheduler: RTL and testbench

Per-SM warp scheduler that picks the next warp to fetch and drives the instruction fetch unit's `din` handshake. It holds PC, thread mask and split-table index for every resident warp. It arbitrates round-robin among fetch-eligible warps and blocks each warp between issue and the PC update returned by decode/branch resolution. It sits between the warp launcher, the instruction fetch unit and the writeback/branch path.

---
 rtl/gelato_fetch_scheduler_if.sv | 56 +++++
 rtl/gelato_fetch_scheduler.sv | 133 +++++++++++++
 tb/tb_gelato_fetch_scheduler.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/gelato_fetch_scheduler_if.sv
// rtl/gelato_fetch_scheduler_if.sv - launch, fetch-issue and PC-update bundle for the fetch scheduler
//
// master : scheduler side (accepts launches/updates, drives the fetch slot, launch_ready, err)
// slave  : environment side (launcher, instruction fetch, decode/branch writeback)
// rdy    : global enable, driven by the environment
interface gelato_fetch_scheduler_if #(
    parameter int NUM_WARPS   = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int MASK_WIDTH  = 32,
    parameter int SPLIT_WIDTH = 4,
    parameter int WW          = $clog2(NUM_WARPS)
);
    logic                   rdy;

    logic                   launch_valid;
    logic                   launch_ready;
    logic [WW-1:0]          launch_warp;
    logic [ADDR_WIDTH-1:0]  launch_pc;
    logic [MASK_WIDTH-1:0]  launch_mask;

    logic                   fetch_valid;
    logic                   fetch_ready;
    logic [ADDR_WIDTH-1:0]  fetch_pc;
    logic [WW-1:0]          fetch_warp;
    logic [SPLIT_WIDTH-1:0] fetch_split;
    logic [MASK_WIDTH-1:0]  fetch_mask;

    logic                   upd_valid;
    logic [WW-1:0]          upd_warp;
    logic [ADDR_WIDTH-1:0]  upd_pc;
    logic [MASK_WIDTH-1:0]  upd_mask;
    logic [SPLIT_WIDTH-1:0] upd_split;
    logic                   upd_exit;

    logic                   err;

    modport master (
        input  rdy,
        input  launch_valid, launch_warp, launch_pc, launch_mask,
        output launch_ready,
        output fetch_valid, fetch_pc, fetch_warp, fetch_split, fetch_mask,
        input  fetch_ready,
        input  upd_valid, upd_warp, upd_pc, upd_mask, upd_split, upd_exit,
        output err
    );

    modport slave (
        output rdy,
        output launch_valid, launch_warp, launch_pc, launch_mask,
        input  launch_ready,
        input  fetch_valid, fetch_pc, fetch_warp, fetch_split, fetch_mask,
        output fetch_ready,
        output upd_valid, upd_warp, upd_pc, upd_mask, upd_split, upd_exit,
        input  err
    );
endinterface

// File: rtl/gelato_fetch_scheduler.sv
// rtl/gelato_fetch_scheduler.sv - per-SM round-robin warp fetch scheduler
//
// clk, rst_n : clock, asynchronous active-low reset
// bus.master : rdy enable, launch handshake, registered fetch output slot,
//              PC-update pulse from decode/branch, sticky protocol err flag
module gelato_fetch_scheduler #(
    parameter int NUM_WARPS   = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int MASK_WIDTH  = 32,
    parameter int SPLIT_WIDTH = 4,
    parameter int WW          = $clog2(NUM_WARPS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    gelato_fetch_scheduler_if.master bus
);
    typedef enum logic [1:0] {W_FREE, W_READY, W_INFLIGHT} warp_state_e;

    warp_state_e            state_q [NUM_WARPS];
    warp_state_e            state_d [NUM_WARPS];
    logic [ADDR_WIDTH-1:0]  pc_q    [NUM_WARPS];
    logic [MASK_WIDTH-1:0]  mask_q  [NUM_WARPS];
    logic [SPLIT_WIDTH-1:0] split_q [NUM_WARPS];
    logic [WW-1:0]          rr_ptr_q;

    logic                   fetch_valid_q;
    logic [ADDR_WIDTH-1:0]  fetch_pc_q;
    logic [WW-1:0]          fetch_warp_q;
    logic [SPLIT_WIDTH-1:0] fetch_split_q;
    logic [MASK_WIDTH-1:0]  fetch_mask_q;
    logic                   err_q;

    logic                   launch_fire;
    logic                   load_en;
    logic                   upd_ok;
    logic                   upd_apply;
    logic                   upd_bad;
    logic                   sel_found;
    logic [WW-1:0]          sel_warp;
    logic [WW-1:0]          scan_idx;

    assign bus.launch_ready = bus.rdy && (state_q[bus.launch_warp] == W_FREE);
    assign launch_fire      = bus.launch_valid && bus.launch_ready;
    // The slot refills when empty or when its current entry is being taken.
    assign load_en          = bus.rdy && (!fetch_valid_q || bus.fetch_ready);

    // A warp still sitting in the output slot has not been fetched yet, so an
    // update for it cannot be a genuine response.
    assign upd_ok    = (state_q[bus.upd_warp] == W_INFLIGHT) &&
                       !(fetch_valid_q && (fetch_warp_q == bus.upd_warp));
    assign upd_apply = bus.rdy && bus.upd_valid && upd_ok;
    assign upd_bad   = bus.rdy && bus.upd_valid && !upd_ok;

    // Scan from rr_ptr with wrap; NUM_WARPS is a power of two so WW-bit
    // addition wraps naturally. Uses registered state, so warps made READY
    // this cycle wait until the next one.
    always_comb begin
        sel_found = 1'b0;
        sel_warp  = '0;
        scan_idx  = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            scan_idx = rr_ptr_q + WW'(i);
            if (!sel_found && state_q[scan_idx] == W_READY) begin
                sel_found = 1'b1;
                sel_warp  = scan_idx;
            end
        end
    end

    // Launch, update and selection always target distinct warps.
    always_comb begin
        state_d = state_q;
        if (launch_fire) begin
            state_d[bus.launch_warp] = W_READY;
        end
        if (upd_apply) begin
            state_d[bus.upd_warp] = bus.upd_exit ? W_FREE : W_READY;
        end
        if (load_en && sel_found) begin
            state_d[sel_warp] = W_INFLIGHT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WARPS; i++) begin
                state_q[i] <= W_FREE;
                pc_q[i]    <= '0;
                mask_q[i]  <= '0;
                split_q[i] <= '0;
            end
            rr_ptr_q      <= '0;
            fetch_valid_q <= 1'b0;
            fetch_pc_q    <= '0;
            fetch_warp_q  <= '0;
            fetch_split_q <= '0;
            fetch_mask_q  <= '0;
            err_q         <= 1'b0;
        end else if (bus.rdy) begin
            state_q <= state_d;
            if (launch_fire) begin
                pc_q[bus.launch_warp]    <= bus.launch_pc;
                mask_q[bus.launch_warp]  <= bus.launch_mask;
                split_q[bus.launch_warp] <= '0;
            end
            if (upd_apply && !bus.upd_exit) begin
                pc_q[bus.upd_warp]    <= bus.upd_pc;
                mask_q[bus.upd_warp]  <= bus.upd_mask;
                split_q[bus.upd_warp] <= bus.upd_split;
            end
            if (load_en) begin
                fetch_valid_q <= sel_found;
                if (sel_found) begin
                    fetch_pc_q    <= pc_q[sel_warp];
                    fetch_warp_q  <= sel_warp;
                    fetch_split_q <= split_q[sel_warp];
                    fetch_mask_q  <= mask_q[sel_warp];
                    rr_ptr_q      <= sel_warp + 1'b1;
                end
            end
            if (upd_bad) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.fetch_valid = fetch_valid_q;
    assign bus.fetch_pc    = fetch_pc_q;
    assign bus.fetch_warp  = fetch_warp_q;
    assign bus.fetch_split = fetch_split_q;
    assign bus.fetch_mask  = fetch_mask_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_gelato_fetch_scheduler.sv
// tb/tb_gelato_fetch_scheduler.sv - directed self-checking bench for gelato_fetch_scheduler
module tb_gelato_fetch_scheduler;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    gelato_fetch_scheduler_if bus ();

    gelato_fetch_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input logic v, input logic [1:0] w, input logic [31:0] pc,
                           input logic [31:0] mask, input logic [3:0] split, input logic ex);
        bus.upd_valid = v;
        bus.upd_warp  = w;
        bus.upd_pc    = pc;
        bus.upd_mask  = mask;
        bus.upd_split = split;
        bus.upd_exit  = ex;
    endtask

    task automatic set_launch(input logic v, input logic [1:0] w, input logic [31:0] pc,
                              input logic [31:0] mask);
        bus.launch_valid = v;
        bus.launch_warp  = w;
        bus.launch_pc    = pc;
        bus.launch_mask  = mask;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", bus.fetch_valid); end
        checks++; if ({bus.fetch_pc, bus.fetch_warp, bus.fetch_split, bus.fetch_mask} !== 70'h0) begin errors++; $display("FAIL reset_slot: pc=%h warp=%0d split=%0d mask=%h want all 0", bus.fetch_pc, bus.fetch_warp, bus.fetch_split, bus.fetch_mask); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", bus.err); end
        rst_n = 1'b1;
        #1;
        checks++; if (bus.launch_ready !== 1'b1) begin errors++; $display("FAIL reset_launch_ready: got %0b want 1", bus.launch_ready); end
    endtask

    task automatic test_single_launch(input string tag);
        bus.fetch_ready = 1'b1;
        set_launch(1'b1, 2'd2, 32'h100, 32'hFFFF_FFFF);
        #1;
        checks++; if (bus.launch_ready !== 1'b1) begin errors++; $display("FAIL %s_lready: got %0b want 1", tag, bus.launch_ready); end
        tick();
        bus.launch_valid = 1'b0;
        checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL %s_latency: fetch_valid=%0b want 0", tag, bus.fetch_valid); end
        tick();
        checks++; if ({bus.fetch_valid, bus.fetch_warp, bus.fetch_pc, bus.fetch_split} !== {1'b1, 2'd2, 32'h100, 4'd0}) begin errors++; $display("FAIL %s_issue: valid=%0b warp=%0d pc=%h split=%0d want 1/2/100/0", tag, bus.fetch_valid, bus.fetch_warp, bus.fetch_pc, bus.fetch_split); end
        checks++; if (bus.fetch_mask !== 32'hFFFF_FFFF) begin errors++; $display("FAIL %s_mask: got %h want ffffffff", tag, bus.fetch_mask); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL %s_err: got %0b want 0", tag, bus.err); end
        tick();
        checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL %s_drain: fetch_valid=%0b want 0", tag, bus.fetch_valid); end
    endtask

    task automatic test_round_robin();
        logic [1:0]  ew;
        logic [31:0] ep;
        test_reset();
        bus.fetch_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_launch(1'b1, 2'(i), 32'(i * 64), 32'hF << (4 * i));
            tick();
            if (i > 0) begin
                ew = 2'(i - 1);
                ep = 32'((i - 1) * 64);
                checks++; if ({bus.fetch_valid, bus.fetch_warp, bus.fetch_pc} !== {1'b1, ew, ep}) begin errors++; $display("FAIL rr_issue%0d: valid=%0b warp=%0d pc=%h want 1/%0d/%h", i - 1, bus.fetch_valid, bus.fetch_warp, bus.fetch_pc, ew, ep); end
            end
        end
        bus.launch_valid = 1'b0;
        tick();
        checks++; if ({bus.fetch_valid, bus.fetch_warp, bus.fetch_pc, bus.fetch_mask} !== {1'b1, 2'd3, 32'hC0, 32'hF000}) begin errors++; $display("FAIL rr_issue3: valid=%0b warp=%0d pc=%h mask=%h want 1/3/c0/f000", bus.fetch_valid, bus.fetch_warp, bus.fetch_pc, bus.fetch_mask); end
        tick();
        checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL rr_drain: fetch_valid=%0b want 0", bus.fetch_valid); end
    endtask

    task automatic test_backpressure();
        bus.fetch_ready = 1'b0;
        set_upd(1'b1, 2'd1, 32'h44, 32'hF0F0, 4'd1, 1'b0);
        tick();
        checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL bp_upd_latency: fetch_valid=%0b want 0", bus.fetch_valid); end
        set_upd(1'b1, 2'd3, 32'hC4, 32'hFF00, 4'd2, 1'b0);
        for (int c = 0; c < 2; c++) begin
            tick();
            if (c == 0) set_upd(1'b1, 2'd0, 32'h04, 32'h000F, 4'd3, 1'b0);
            checks++; if ({bus.fetch_valid, bus.fetch_warp, bus.fetch_pc, bus.fetch_mask, bus.fetch_split} !== {1'b1, 2'd1, 32'h44, 32'hF0F0, 4'd1}) begin errors++; $display("FAIL bp_hold%0d: valid=%0b warp=%0d pc=%h mask=%h split=%0d want 1/1/44/f0f0/1", c, bus.fetch_valid, bus.fetch_warp, bus.fetch_pc, bus.fetch_mask, bus.fetch_split); end
        end
        set_upd(1'b1, 2'd1, 32'hDEAD, 32'h0, 4'd7, 1'b0);
        #1;
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL bp_err_before: got %0b want 0", bus.err); end
        tick();
        bus.upd_valid = 1'b0;
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL bp_err_set: got %0b want 1", bus.err); end
        checks++; if ({bus.fetch_valid, bus.fetch_warp, bus.fetch_pc, bus.fetch_split} !== {1'b1, 2'd1, 32'h44, 4'd1}) begin errors++; $display("FAIL bp_hold2: valid=%0b warp=%0d pc=%h split=%0d want 1/1/44/1", bus.fetch_valid, bus.fetch_warp, bus.fetch_pc, bus.fetch_split); end
        bus.fetch_ready = 1'b1;
        tick();
        checks++; if ({bus.fetch_valid, bus.fetch_warp, bus.fetch_pc, bus.fetch_split} !== {1'b1, 2'd3, 32'hC4, 4'd2}) begin errors++; $display("FAIL bp_wrap_first: valid=%0b warp=%0d pc=%h split=%0d want 1/3/c4/2", bus.fetch_valid, bus.fetch_warp, bus.fetch_pc, bus.fetch_split); end
        tick();
        checks++; if ({bus.fetch_valid, bus.fetch_warp, bus.fetch_pc, bus.fetch_split} !== {1'b1, 2'd0, 32'h04, 4'd3}) begin errors++; $display("FAIL bp_wrap_second: valid=%0b warp=%0d pc=%h split=%0d want 1/0/4/3", bus.fetch_valid, bus.fetch_warp, bus.fetch_pc, bus.fetch_split); end
        tick();
        checks++; if ({bus.fetch_valid, bus.err} !== 2'b01) begin errors++; $display("FAIL bp_drain: valid=%0b err=%0b want 0/1", bus.fetch_valid, bus.err); end
    endtask

    task automatic test_exit_relaunch();
        bus.launch_warp = 2'd0;
        set_upd(1'b1, 2'd0, 32'h0, 32'h0, 4'd0, 1'b1);
        #1;
        checks++; if (bus.launch_ready !== 1'b0) begin errors++; $display("FAIL exit_same_cycle: launch_ready=%0b want 0", bus.launch_ready); end
        tick();
        bus.upd_valid = 1'b0;
        checks++; if (bus.launch_ready !== 1'b1) begin errors++; $display("FAIL exit_next_cycle: launch_ready=%0b want 1", bus.launch_ready); end
        set_launch(1'b1, 2'd0, 32'h200, 32'hFF);
        tick();
        bus.launch_valid = 1'b0;
        tick();
        checks++; if ({bus.fetch_valid, bus.fetch_warp, bus.fetch_pc, bus.fetch_split, bus.fetch_mask} !== {1'b1, 2'd0, 32'h200, 4'd0, 32'hFF}) begin errors++; $display("FAIL relaunch_issue: valid=%0b warp=%0d pc=%h split=%0d mask=%h want 1/0/200/0/ff", bus.fetch_valid, bus.fetch_warp, bus.fetch_pc, bus.fetch_split, bus.fetch_mask); end
        tick();
    endtask

    task automatic test_rdy_freeze();
        set_upd(1'b1, 2'd2, 32'h0, 32'h0, 4'd0, 1'b1);
        tick();
        bus.fetch_ready = 1'b0;
        set_upd(1'b1, 2'd1, 32'h48, 32'h3, 4'd4, 1'b0);
        tick();
        bus.upd_valid = 1'b0;
        tick();
        checks++; if ({bus.fetch_valid, bus.fetch_warp, bus.fetch_pc} !== {1'b1, 2'd1, 32'h48}) begin errors++; $display("FAIL frz_setup: valid=%0b warp=%0d pc=%h want 1/1/48", bus.fetch_valid, bus.fetch_warp, bus.fetch_pc); end
        bus.rdy = 1'b0;
        set_launch(1'b1, 2'd2, 32'h300, 32'h5);
        bus.fetch_ready = 1'b1;
        set_upd(1'b1, 2'd3, 32'h0, 32'h0, 4'd0, 1'b1);
        #1;
        checks++; if (bus.launch_ready !== 1'b0) begin errors++; $display("FAIL frz_lready: got %0b want 0", bus.launch_ready); end
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++; if ({bus.fetch_valid, bus.fetch_warp, bus.fetch_pc, bus.fetch_split} !== {1'b1, 2'd1, 32'h48, 4'd4}) begin errors++; $display("FAIL frz_hold%0d: valid=%0b warp=%0d pc=%h split=%0d want 1/1/48/4", c, bus.fetch_valid, bus.fetch_warp, bus.fetch_pc, bus.fetch_split); end
        end
        bus.upd_valid = 1'b0;
        bus.rdy = 1'b1;
        bus.launch_warp = 2'd3;
        #1;
        checks++; if (bus.launch_ready !== 1'b0) begin errors++; $display("FAIL frz_upd_ignored: warp3 launch_ready=%0b want 0", bus.launch_ready); end
        bus.launch_warp = 2'd2;
        #1;
        checks++; if (bus.launch_ready !== 1'b1) begin errors++; $display("FAIL frz_launch_ignored: warp2 launch_ready=%0b want 1", bus.launch_ready); end
        tick();
        bus.launch_valid = 1'b0;
        checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL frz_resume_drain: fetch_valid=%0b want 0", bus.fetch_valid); end
        tick();
        checks++; if ({bus.fetch_valid, bus.fetch_warp, bus.fetch_pc, bus.fetch_mask} !== {1'b1, 2'd2, 32'h300, 32'h5}) begin errors++; $display("FAIL frz_resume_issue: valid=%0b warp=%0d pc=%h mask=%h want 1/2/300/5", bus.fetch_valid, bus.fetch_warp, bus.fetch_pc, bus.fetch_mask); end
        bus.fetch_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.fetch_valid, bus.err} !== 2'b00) begin errors++; $display("FAIL areset_flags: valid=%0b err=%0b want 0/0", bus.fetch_valid, bus.err); end
        checks++; if ({bus.fetch_pc, bus.fetch_warp, bus.fetch_split, bus.fetch_mask} !== 70'h0) begin errors++; $display("FAIL areset_slot: pc=%h warp=%0d split=%0d mask=%h want all 0", bus.fetch_pc, bus.fetch_warp, bus.fetch_split, bus.fetch_mask); end
        checks++; if (bus.launch_ready !== 1'b1) begin errors++; $display("FAIL areset_lready: got %0b want 1", bus.launch_ready); end
        tick();
        rst_n = 1'b1;
        test_single_launch("post_reset");
    endtask

    initial begin
        rst_n = 1'b0;
        bus.rdy = 1'b1;
        bus.fetch_ready = 1'b1;
        set_launch(1'b0, 2'd0, 32'h0, 32'h0);
        set_upd(1'b0, 2'd0, 32'h0, 32'h0, 4'd0, 1'b0);
        test_reset();
        test_single_launch("single");
        test_round_robin();
        test_backpressure();
        test_exit_relaunch();
        test_rdy_freeze();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
